// File: rtl/s2mm_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one MCDMA S2MM AXI-Stream port
// between NUM_CHANNELS first-word-fall-through result FIFOs.
module s2mm_packet_arbiter #(
    parameter int unsigned AXIS_DATA_WIDTH = 32,
    parameter int unsigned FIFO_DATA_WIDTH = 32,
    parameter int unsigned AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int unsigned AXIS_DEST_WIDTH = 4,
    parameter int unsigned NUM_CHANNELS    = 2,
    parameter int unsigned MAX_BEATS       = 1024
) (
    input  logic                                    clk_in,
    input  logic                                    rst_n_in,
    input  logic [NUM_CHANNELS-1:0]                 chan_en_in,
    input  logic                                    SINK_AXIS_tready_in,
    output logic [AXIS_DATA_WIDTH-1:0]              SINK_AXIS_tdata_out,
    output logic [AXIS_DEST_WIDTH-1:0]              SINK_AXIS_tdest_out,
    output logic [AXIS_KEEP_WIDTH-1:0]              SINK_AXIS_tkeep_out,
    output logic                                    SINK_AXIS_tlast_out,
    output logic                                    SINK_AXIS_tuser_out,
    output logic                                    SINK_AXIS_tvalid_out,
    input  logic [FIFO_DATA_WIDTH*NUM_CHANNELS-1:0] fifo_data_in,
    input  logic [NUM_CHANNELS-1:0]                 fifo_not_empty_in,
    input  logic [NUM_CHANNELS-1:0]                 fifo_last_in,
    output logic [NUM_CHANNELS-1:0]                 fifo_r_stb_out,
    output logic [NUM_CHANNELS-1:0]                 overrun_out,
    output logic [1:0]                              dbg_state
);

    localparam int unsigned IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1
    } state_t;

    state_t                     state;
    logic [IDX_W-1:0]           grant;
    logic [IDX_W-1:0]           last_grant;
    logic [CNT_W-1:0]           beat_count;

    logic [NUM_CHANNELS-1:0]    req;
    logic [NUM_CHANNELS-1:0]    grant_oh;
    logic [IDX_W-1:0]           win_idx;
    logic [IDX_W-1:0]           cand;
    logic                       win_found;
    logic [FIFO_DATA_WIDTH-1:0] head_data;
    logic                       head_last;
    logic                       head_valid;
    logic                       out_free;
    logic                       pop;
    logic                       force_last;
    logic                       pop_last;

    assign req = fifo_not_empty_in & chan_en_in;

    // Round-robin search starting just after the previously served channel
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_CHANNELS; k++) begin
            cand = IDX_W'((32'(last_grant) + k) % NUM_CHANNELS);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Head-of-FIFO view of the granted channel
    always_comb begin
        head_data  = '0;
        head_last  = 1'b0;
        head_valid = 1'b0;
        grant_oh   = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            if (grant == IDX_W'(i)) begin
                head_data   = fifo_data_in[i*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
                head_last   = fifo_last_in[i];
                head_valid  = fifo_not_empty_in[i];
                grant_oh[i] = 1'b1;
            end
        end
    end

    // Pop is combinational from tready so the output slot refills every cycle
    assign out_free       = !SINK_AXIS_tvalid_out || SINK_AXIS_tready_in;
    assign pop            = rst_n_in && (state == ST_XFER) && head_valid && out_free;
    assign force_last     = (beat_count == CNT_W'(MAX_BEATS - 1));
    assign pop_last       = head_last || force_last;
    assign fifo_r_stb_out = pop ? grant_oh : '0;

    assign SINK_AXIS_tkeep_out = '1;
    assign SINK_AXIS_tuser_out = 1'b0;
    assign dbg_state           = state;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state                <= ST_IDLE;
            grant                <= '0;
            last_grant           <= IDX_W'(NUM_CHANNELS - 1);
            beat_count           <= '0;
            overrun_out          <= '0;
            SINK_AXIS_tvalid_out <= 1'b0;
            SINK_AXIS_tlast_out  <= 1'b0;
            SINK_AXIS_tdata_out  <= '0;
            SINK_AXIS_tdest_out  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        grant <= win_idx;
                        state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (pop && pop_last) begin
                        last_grant <= grant;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (pop) begin
                SINK_AXIS_tdata_out  <= AXIS_DATA_WIDTH'(head_data);
                SINK_AXIS_tdest_out  <= AXIS_DEST_WIDTH'(grant);
                SINK_AXIS_tlast_out  <= pop_last;
                SINK_AXIS_tvalid_out <= 1'b1;
                beat_count           <= pop_last ? '0 : beat_count + CNT_W'(1);
                // A packet longer than MAX_BEATS is cut here; remember it per channel
                if (force_last && !head_last) begin
                    overrun_out[grant] <= 1'b1;
                end
            end else if (SINK_AXIS_tready_in) begin
                SINK_AXIS_tvalid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_s2mm_packet_arbiter.sv
// Bench for s2mm_packet_arbiter: queue-based FIFO/stream model plus directed
// vector table, hand sequences for multi-cycle corners, and random traffic.
module tb_s2mm_packet_arbiter;

    localparam int unsigned DW     = 32;
    localparam int unsigned NCH    = 3;
    localparam int unsigned IW     = 2;
    localparam int unsigned DEST_W = 4;
    localparam int unsigned KEEP_W = DW / 8;
    localparam int unsigned MAXB   = 8;

    logic                   clk;
    logic                   rst_n;
    logic [NCH-1:0]         chan_en;
    logic                   tready;
    logic [DW-1:0]          tdata;
    logic [DEST_W-1:0]      tdest;
    logic [KEEP_W-1:0]      tkeep;
    logic                   tlast;
    logic                   tuser;
    logic                   tvalid;
    logic [NCH-1:0][DW-1:0] fd;
    logic [NCH-1:0]         fifo_ne;
    logic [NCH-1:0]         fifo_last;
    logic [NCH-1:0]         stb;
    logic [NCH-1:0]         overrun;
    logic [1:0]             dbg_state;

    s2mm_packet_arbiter #(
        .AXIS_DATA_WIDTH (DW),
        .FIFO_DATA_WIDTH (DW),
        .AXIS_KEEP_WIDTH (KEEP_W),
        .AXIS_DEST_WIDTH (DEST_W),
        .NUM_CHANNELS    (NCH),
        .MAX_BEATS       (MAXB)
    ) dut (
        .clk_in               (clk),
        .rst_n_in             (rst_n),
        .chan_en_in           (chan_en),
        .SINK_AXIS_tready_in  (tready),
        .SINK_AXIS_tdata_out  (tdata),
        .SINK_AXIS_tdest_out  (tdest),
        .SINK_AXIS_tkeep_out  (tkeep),
        .SINK_AXIS_tlast_out  (tlast),
        .SINK_AXIS_tuser_out  (tuser),
        .SINK_AXIS_tvalid_out (tvalid),
        .fifo_data_in         (fd),
        .fifo_not_empty_in    (fifo_ne),
        .fifo_last_in         (fifo_last),
        .fifo_r_stb_out       (stb),
        .overrun_out          (overrun),
        .dbg_state            (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    typedef struct {
        logic [DW-1:0]     data;
        logic [DEST_W-1:0] dest;
        logic              last;
    } beat_t;

    typedef struct {
        int             ch;
        int             nbeats;
        int             exp_nout;
        logic [15:0]    exp_lmask;
        logic [NCH-1:0] exp_ovr;
    } vec_t;

    word_t fq [NCH][$];
    beat_t seen[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_stb    = 0;

    // Reference model state: packet-level view of the arbiter
    bit             m_arb    = 1'b1;
    int             m_cur    = 0;
    int             m_last_g = NCH - 1;
    bit             m_pend   = 1'b0;
    beat_t          m_beat;
    int             m_cnt    = 0;
    logic [NCH-1:0] m_ovr    = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NCH-1:0] req, input int last);
        int c;
        for (int k = 1; k <= int'(NCH); k++) begin
            c = (last + k) % int'(NCH);
            if (req[IW'(c)]) return c;
        end
        return -1;
    endfunction

    function automatic bit fq_empty();
        for (int i = 0; i < int'(NCH); i++) begin
            if (fq[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drive_heads();
        for (int i = 0; i < int'(NCH); i++) begin
            if (fq[i].size() != 0) begin
                fd[IW'(i)]        = fq[i][0].data;
                fifo_last[IW'(i)] = fq[i][0].last;
                fifo_ne[IW'(i)]   = 1'b1;
            end else begin
                fd[IW'(i)]        = '0;
                fifo_last[IW'(i)] = 1'b0;
                fifo_ne[IW'(i)]   = 1'b0;
            end
        end
    endtask

    // Monitor: check at negedge, then advance FIFOs and model after the edge
    always begin : monitor
        logic [NCH-1:0] req;
        logic [NCH-1:0] exp_stb;
        logic [NCH-1:0] stb_s;
        logic           rst_s;
        logic           tr_s;
        int             win;
        int             pc;
        word_t          w;
        beat_t          b;

        @(negedge clk);
        rst_s = rst_n;
        tr_s  = tready;
        stb_s = stb;
        win   = -1;
        req   = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            req[IW'(i)] = (fq[i].size() != 0) && chan_en[IW'(i)];
        end

        if (!rst_s) begin
            chk("stb_in_reset", 64'(stb_s), 64'(0));
        end else if (m_arb) begin
            chk("stb_arb_bubble", 64'(stb_s), 64'(0));
            if (req != '0) win = rr_pick(req, m_last_g);
        end else begin
            exp_stb = '0;
            if (fq[m_cur].size() != 0 && (!m_pend || tr_s)) exp_stb[IW'(m_cur)] = 1'b1;
            chk("r_stb", 64'(stb_s), 64'(exp_stb));
        end

        chk("tvalid", 64'(tvalid), 64'(m_pend));
        if (m_pend) begin
            chk("tdata", 64'(tdata), 64'(m_beat.data));
            chk("tdest", 64'(tdest), 64'(m_beat.dest));
            chk("tlast", 64'(tlast), 64'(m_beat.last));
        end
        chk("overrun", 64'(overrun), 64'(m_ovr));
        chk("tkeep", 64'(tkeep), 64'({KEEP_W{1'b1}}));
        chk("tuser", 64'(tuser), 64'(0));
        if (tvalid && tready) begin
            b.data = tdata;
            b.dest = tdest;
            b.last = tlast;
            seen.push_back(b);
        end
        n_stb += $countones(stb_s);

        @(posedge clk);
        #1;
        if (!rst_s) begin
            m_arb    = 1'b1;
            m_last_g = NCH - 1;
            m_pend   = 1'b0;
            m_cnt    = 0;
            m_ovr    = '0;
        end else begin
            pc = -1;
            for (int i = int'(NCH) - 1; i >= 0; i--) begin
                if (stb_s[IW'(i)]) pc = i;
            end
            if (pc >= 0 && fq[pc].size() != 0) begin
                w      = fq[pc].pop_front();
                b.data = w.data;
                b.dest = DEST_W'(m_cur);
                b.last = w.last || (m_cnt == int'(MAXB) - 1);
                m_beat = b;
                m_pend = 1'b1;
                if (b.last) begin
                    if (!w.last) m_ovr[IW'(m_cur)] = 1'b1;
                    m_cnt    = 0;
                    m_arb    = 1'b1;
                    m_last_g = m_cur;
                end else begin
                    m_cnt++;
                end
            end else if (m_pend && tr_s) begin
                m_pend = 1'b0;
            end
            if (win >= 0) begin
                m_arb = 1'b0;
                m_cur = win;
            end
        end
        #2;
        drive_heads();
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        cyc(n);
        rst_n = 1'b1;
    endtask

    task automatic push_pkt(input int ch, input int n, input logic [7:0] tag);
        word_t w;
        for (int i = 0; i < n; i++) begin
            w.data = {tag, 8'(ch), 16'(i)};
            w.last = (i == n - 1);
            fq[ch].push_back(w);
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        logic done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            cyc(1);
            done = fq_empty() && !m_pend && m_arb;
        end
        chk(name, 64'(done), 64'(1));
    endtask

    task automatic wait_seen(input int n, input int budget, input string name);
        logic done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            cyc(1);
            done = (seen.size() >= n);
        end
        chk(name, 64'(done), 64'(1));
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        vec_t        vt[6];
        logic [15:0] lm;
        logic [7:0]  pat;
        int          k0;
        int          tot;
        bit          any_last;

        rst_n     = 1'b0;
        chan_en   = '1;
        tready    = 1'b1;
        fd        = '0;
        fifo_ne   = '0;
        fifo_last = '0;

        vt[0] = '{ch: 0, nbeats: 4,  exp_nout: 4,  exp_lmask: 16'h0008, exp_ovr: 3'b000};
        vt[1] = '{ch: 1, nbeats: 1,  exp_nout: 1,  exp_lmask: 16'h0001, exp_ovr: 3'b000};
        vt[2] = '{ch: 0, nbeats: 10, exp_nout: 10, exp_lmask: 16'h0280, exp_ovr: 3'b001};
        vt[3] = '{ch: 2, nbeats: 8,  exp_nout: 8,  exp_lmask: 16'h0080, exp_ovr: 3'b001};
        vt[4] = '{ch: 1, nbeats: 16, exp_nout: 16, exp_lmask: 16'h8080, exp_ovr: 3'b011};
        vt[5] = '{ch: 2, nbeats: 9,  exp_nout: 9,  exp_lmask: 16'h0180, exp_ovr: 3'b111};

        cyc(3);
        chk("reset_tvalid", 64'(tvalid), 64'(0));
        chk("reset_tdata", 64'(tdata), 64'(0));
        chk("reset_state", 64'(dbg_state), 64'(0));
        rst_n = 1'b1;
        cyc(2);

        // Single-packet vectors, including forced-tlast splits
        for (int v = 0; v < 6; v++) begin
            seen.delete();
            push_pkt(vt[v].ch, vt[v].nbeats, 8'(v));
            wait_drain(200, "vec_drain");
            chk("vec_nbeats", 64'(seen.size()), 64'(vt[v].exp_nout));
            lm = '0;
            for (int j = 0; j < seen.size() && j < 16; j++) begin
                lm[4'(j)] = seen[j].last;
                chk("vec_dest", 64'(seen[j].dest), 64'(vt[v].ch));
                chk("vec_data", 64'(seen[j].data), 64'({8'(v), 8'(vt[v].ch), 16'(j)}));
            end
            chk("vec_tlast_mask", 64'(lm), 64'(vt[v].exp_lmask));
            chk("vec_overrun", 64'(overrun), 64'(vt[v].exp_ovr));
        end

        // Two continuous requesters alternate packet by packet
        do_reset(1);
        seen.delete();
        for (int p = 0; p < 3; p++) begin
            push_pkt(0, 3, 8'(16 + p));
            push_pkt(1, 3, 8'(32 + p));
        end
        wait_drain(300, "rr_drain");
        chk("rr_nbeats", 64'(seen.size()), 64'(18));
        for (int j = 0; j < seen.size(); j++) begin
            chk("rr_dest", 64'(seen[j].dest), 64'((j / 3) % 2));
            chk("rr_last", 64'(seen[j].last), 64'((j % 3) == 2));
        end

        // Back-pressure with a toggling tready
        do_reset(1);
        seen.delete();
        n_stb = 0;
        push_pkt(1, 4, 8'h40);
        pat = 8'b1110_1001;
        for (int i = 0; i < 8; i++) begin
            tready = pat[i];
            cyc(1);
        end
        tready = 1'b1;
        wait_drain(100, "bp_drain");
        chk("bp_handshakes", 64'(seen.size()), 64'(4));
        chk("bp_stb_pulses", 64'(n_stb), 64'(4));
        for (int j = 0; j < seen.size(); j++) begin
            chk("bp_dest", 64'(seen[j].dest), 64'(1));
            chk("bp_last", 64'(seen[j].last), 64'(j == 3));
        end

        // Channel mask is sampled only between packets
        do_reset(1);
        seen.delete();
        chan_en = 3'b001;
        push_pkt(1, 3, 8'h50);
        push_pkt(0, 5, 8'h51);
        wait_seen(2, 50, "mask_start");
        chan_en = 3'b000;
        cyc(30);
        chk("mask_nbeats", 64'(seen.size()), 64'(5));
        for (int j = 0; j < seen.size(); j++) begin
            chk("mask_dest", 64'(seen[j].dest), 64'(0));
        end
        chk("mask_ch1_waiting", 64'(fq[1].size()), 64'(3));
        chk("mask_idle", 64'(dbg_state), 64'(0));
        chan_en = '1;
        wait_drain(100, "mask_drain");
        chk("mask_total", 64'(seen.size()), 64'(8));

        // Reset in the middle of a packet
        do_reset(1);
        seen.delete();
        push_pkt(1, 5, 8'h60);
        wait_seen(2, 50, "rst_mid_start");
        rst_n = 1'b0;
        push_pkt(0, 1, 8'h61);
        cyc(1);
        rst_n = 1'b1;
        chk("rst_mid_tvalid", 64'(tvalid), 64'(0));
        chk("rst_mid_state", 64'(dbg_state), 64'(0));
        chk("rst_mid_tlast", 64'(tlast), 64'(0));
        chk("rst_mid_tdest", 64'(tdest), 64'(0));
        any_last = 1'b0;
        for (int j = 0; j < seen.size(); j++) any_last |= seen[j].last;
        chk("rst_mid_no_tlast", 64'(any_last), 64'(0));
        k0 = seen.size();
        wait_drain(100, "rst_mid_drain");
        if (seen.size() > k0) begin
            chk("rst_mid_first_dest", 64'(seen[k0].dest), 64'(0));
            chk("rst_mid_first_last", 64'(seen[k0].last), 64'(1));
            chk("rst_mid_tail_dest", 64'(seen[seen.size()-1].dest), 64'(1));
            chk("rst_mid_tail_last", 64'(seen[seen.size()-1].last), 64'(1));
        end else begin
            chk("rst_mid_beats_after", 64'(seen.size()), 64'(k0 + 1));
        end

        // Random traffic against the model
        do_reset(1);
        for (int c = 0; c < 3000; c++) begin
            tot = 0;
            for (int i = 0; i < int'(NCH); i++) tot += fq[i].size();
            if ($urandom_range(0, 3) == 0 && tot < 60) begin
                push_pkt(int'($urandom_range(0, NCH - 1)), int'($urandom_range(1, 12)),
                         8'($urandom));
            end
            tready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 99) == 0) chan_en = NCH'($urandom_range(1, 7));
            rst_n = ($urandom_range(0, 599) != 0);
            cyc(1);
        end
        rst_n   = 1'b1;
        chan_en = '1;
        tready  = 1'b1;
        wait_drain(3000, "final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/s2mm_packet_arbiter.md
Name: s2mm_packet_arbiter

Overview:
Packet-granular round-robin arbiter that shares the single MCDMA S2MM slave AXI-Stream port between NUM_CHANNELS accelerator output FIFOs.
- Locks onto one channel from its first beat until that channel's tlast beat, so packets never interleave on the stream.
- Tags every beat with the channel index in tdest.
- Output is registered with a one-deep pipeline and full ready/valid back-pressure.
- Sits between the per-accelerator result FIFOs (first-word-fall-through) and the MCDMA S2MM port.

Parameters:
AXIS_DATA_WIDTH, 32, width of the output tdata.
FIFO_DATA_WIDTH, 32, width of each FIFO word; must equal AXIS_DATA_WIDTH.
AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, width of tkeep.
AXIS_DEST_WIDTH, 4, width of tdest; must satisfy 2^AXIS_DEST_WIDTH >= NUM_CHANNELS.
NUM_CHANNELS, 2, number of FIFO requesters (2..16).
MAX_BEATS, 1024, maximum beats per packet before tlast is forced.

Ports:
clk_in  in  1  clock; all logic on its rising edge.
rst_n_in  in  1  reset; synchronous, active-low.
chan_en_in  in  NUM_CHANNELS  per-channel arbitration enable mask.
SINK_AXIS_tready_in  in  1  ready from the MCDMA S2MM port.
SINK_AXIS_tdata_out  out  AXIS_DATA_WIDTH  beat data.
SINK_AXIS_tdest_out  out  AXIS_DEST_WIDTH  granted channel index.
SINK_AXIS_tkeep_out  out  AXIS_KEEP_WIDTH  constant all-ones.
SINK_AXIS_tlast_out  out  1  end of packet.
SINK_AXIS_tuser_out  out  1  constant 0.
SINK_AXIS_tvalid_out  out  1  beat valid.
fifo_data_in  in  FIFO_DATA_WIDTH*NUM_CHANNELS  FWFT head word; channel i occupies slice [i*W +: W].
fifo_not_empty_in  in  NUM_CHANNELS  head word valid.
fifo_last_in  in  NUM_CHANNELS  head word is the last word of its packet.
fifo_r_stb_out  out  NUM_CHANNELS  pop strobe; one-hot or zero.
overrun_out  out  NUM_CHANNELS  sticky flag: a forced tlast occurred on that channel.
dbg_state  out  2  FSM state encoding: 0 IDLE, 1 XFER.

Behaviour:
Reset (rst_n_in=0 sampled on a clock edge):
- FSM goes to IDLE; grant is cleared.
- last_grant is set to NUM_CHANNELS-1, so channel 0 wins first.
- Beat counter is 0; tvalid, tlast, tdata and tdest are all 0.
- overrun_out is 0 and fifo_r_stb_out is 0 combinationally while in reset.
- Reset mid-packet abandons the packet: no tlast is emitted, and the FIFO remainder is sent later as a new packet.

Output stage:
- Define out_free = !tvalid_reg | SINK_AXIS_tready_in.
- fifo_r_stb_out[g] = (state==XFER) & grant_onehot[g] & fifo_not_empty_in[g] & out_free. This path is combinational from tready.
- On a pop, the output registers load the head word, tdest = g, and tlast as defined below, with tvalid=1 at the next edge.
- When there is no pop and tready=1, tvalid clears.
- While tvalid=1 and tready=0, tdata, tdest, tlast and tvalid hold stable (AXIS rule).
- Latency: pop at edge N gives the beat visible from edge N+1.
- Throughput is one beat per clock when tready is held high.

IDLE state:
- req = fifo_not_empty_in & chan_en_in.
- If req is nonzero, the winner is the first set bit searching last_grant+1, last_grant+2, ... with modulo NUM_CHANNELS wrap.
- Register the winner's grant and go to XFER; there is no pop in the IDLE cycle.
- If req is zero, stay in IDLE.

XFER state:
- Each pop increments the beat counter.
- Popped beat tlast = fifo_last_in[g] | (beat_count == MAX_BEATS-1).
- If tlast was forced (fifo_last_in[g]=0), set overrun_out[g], which stays set until reset.
- On popping a tlast beat: last_grant <= g, beat counter <= 0, return to IDLE.
- The FIFO going empty mid-packet stalls XFER (tvalid drops after the pending beat drains); the grant is held.
- chan_en_in changes in XFER do not affect the current packet; the mask is sampled only in IDLE.

Arbitration overhead and fairness:
- One bubble cycle per packet (the IDLE arbitration cycle).
- Continuous requesters are served strictly in rotation.
- A single requester is re-granted back-to-back with one bubble between packets.

Width rules:
- Beat counter width is $clog2(MAX_BEATS).
- tdest = grant index zero-extended to AXIS_DEST_WIDTH.

Test Plan:
1. NUM_CHANNELS=2; ch0 holds a 4-beat packet, tready=1.
   -> r_stb[0] pulses for 4 consecutive cycles starting 1 cycle after the IDLE arbitration; beats out on 4 consecutive cycles with tdest=0 and tlast only on beat 4.
2. ch0 and ch1 each continuously hold 3-beat packets.
   -> Output tdest sequence 0,0,0,1,1,1,0,0,0 with one bubble between packets; never interleaved.
3. 4-beat packet on ch1; tready toggles 1,0,0,1,0,1,1,1.
   -> tdata/tdest/tlast stable whenever tvalid=1 and tready=0; exactly 4 handshakes; 4 r_stb pulses total.
4. MAX_BEATS=8; ch0 sends 10 beats, last flag on beat 10.
   -> tlast on beat 8 and overrun_out[0]=1; beats 9-10 emitted as a new 2-beat packet with tlast on beat 10.
5. chan_en_in=2'b01 with both FIFOs non-empty; clear chan_en_in[0] mid-packet.
   -> Ch1 is never granted while masked; ch0 completes its current packet before arbitration stops.
6. Assert rst_n_in low for 1 cycle at beat 2 of a 5-beat packet.
   -> tvalid=0 the next cycle; FSM IDLE; the next grant goes to ch0; no tlast emitted for the aborted packet.
